adxl_spi_sequencer: RTL and testbench
=====================================

# adxl_spi_sequencer

Command sequencer that sits directly upstream of the 3-wire SPI controller on the DE0-Nano G-sensor path. After reset it writes a fixed ADXL345 initialisation table, then periodically issues six single-byte register reads (0x32..0x37). It assembles the returned bytes into signed 16-bit X/Y/Z samples with a one-cycle valid strobe. It drives the controller's parallel command word and GO line, and consumes its END flag and deserialised read byte.

## Interface
- GAP_CYCLES, 4: idle cycles with oSPI_GO low (CS high) between consecutive transfers; minimum 2.
- POLL_CYCLES, 1000: cycles from the end of one read burst to the start of the next.
- TIMEOUT_CYCLES, 64: maximum cycles in a transfer waiting for iSPI_END before abort.
- iCLK in 1: single clock, same clock as the SPI controller's bit clock.
- iRST in 1: reset, synchronous, active-high.
- iEN in 1: polling enable; has no effect on the init table.
- oP2S_DATA out 16: command word {R/W, MB=0, addr[5:0], wdata[7:0]} to the controller.
- oSPI_GO out 1: transfer request; held high for the whole transfer.
- iSPI_END in 1: controller end-of-transfer flag.
- iS2P_DATA in 8: byte read back by the controller.
- oX, oY, oZ out 16 each: last complete sample, {DATAx1, DATAx0}.
- oDATA_VALID out 1: one-cycle pulse when oX/oY/oZ update.
- oINIT_DONE out 1: high once the init table has completed.
- oERR out 1: sticky timeout flag.

## Operation
- Init table, in order:
  - 16'h3140: DATA_FORMAT = 3-wire SPI, ±2 g.
  - 16'h2C09: BW_RATE = 50 Hz.
  - 16'h2D08: POWER_CTL = measure.
- Read commands: 16'hB200, B300, B400, B500, B600, B700. Each has bit15 = 1, MB = 0, and wdata 00.
- States:
  - S_IDLE: entered from reset; next cycle goes to S_XFER with init index 0.
  - S_XFER: oSPI_GO = 1 and oP2S_DATA = current command, both stable. Waits for iSPI_END = 1, then goes to S_GAP.
  - S_GAP: oSPI_GO = 0 for GAP_CYCLES cycles. Then:
    - If init entries remain, go to the next init entry.
    - If the last init entry just finished, set oINIT_DONE and go to S_POLL.
    - If read bytes remain, go to the next read.
    - If the 6th read just finished, go to S_POLL.
  - S_POLL: counter runs from 0 to POLL_CYCLES-1, then goes to S_XFER with read index 0. While iEN = 0 the counter holds at 0.
- Read capture:
  - iS2P_DATA is sampled at the end of the first S_GAP cycle after a read, because the controller's final shift lands on the END cycle.
  - The byte goes into a staging register selected by the read index.
  - When the 6th byte is captured, oX/oY/oZ load from staging on that same edge and oDATA_VALID pulses on the following cycle aligned with the new values. oDATA_VALID is high exactly one cycle per burst.
  - Init writes never capture.
- Timeout:
  - The S_XFER cycle counter reaches TIMEOUT_CYCLES without iSPI_END: drop oSPI_GO, set oERR, go to S_GAP.
  - After the gap, restart from init index 0 and clear oINIT_DONE.
  - The partial sample is discarded; oX/oY/oZ keep their old values.
  - If iSPI_END and the timeout coincide, iSPI_END wins and no error is flagged.
- iEN dropping mid-burst does not abort; the burst completes, then the block waits in S_POLL.
- iRST mid-transfer: next edge returns all state and outputs to reset values. oSPI_GO goes low immediately, so CS releases.

## Timing
- Reset values: oP2S_DATA = 0, oSPI_GO = 0, oX/oY/oZ = 0, oDATA_VALID = 0, oINIT_DONE = 0, oERR = 0.
- First oSPI_GO rises 1 cycle after iRST deasserts, carrying 16'h3140.
- oSPI_GO falls on the edge after iSPI_END is sampled high; minimum GO-low gap = GAP_CYCLES.
- With the controller taking 17 cycles from GO to END, one transfer = 18 + GAP_CYCLES cycles. The init table therefore takes 3 × (18 + GAP_CYCLES) cycles; a burst takes 6 × (18 + GAP_CYCLES).
- Burst-start period = POLL_CYCLES + burst length.
- oP2S_DATA changes only while oSPI_GO = 0.

## Test plan
- Reset release with the controller model: GO sequences carry 3140, 2C09, 2D08, each separated by ≥4 low cycles. oINIT_DONE rises after the 3rd gap.
- Sensor model returns 0x34, 0x12, 0xFE, 0xFF, 0x00, 0x01 for 0x32..0x37 -> one oDATA_VALID pulse with oX = 16'h1234, oY = 16'hFFFE, oZ = 16'h0100.
- iEN = 0 after init -> no GO for 5000 cycles. Set iEN = 1 -> first GO carrying B200 after POLL_CYCLES.
- Controller model never asserts END on the 2nd read:
  - GO drops after 64 cycles and oERR = 1.
  - oX/oY/oZ unchanged.
  - Next command is 3140 and oINIT_DONE = 0.
- END and the timeout in the same cycle -> oERR stays 0 and the sequence continues.
- iRST pulsed during the 4th read's S_XFER -> all outputs zero next cycle, oSPI_GO = 0, then a fresh 3140.

Source files
------------

// File: rtl/adxl_spi_sequencer_if.sv
// Parallel command/response link between the ADXL345 sequencer and the 3-wire SPI controller.
// Signal names are given from the sequencer's point of view.
interface adxl_spi_sequencer_if;
   logic [15:0] oP2S_DATA;
   logic        oSPI_GO;
   logic        iSPI_END;
   logic [7:0]  iS2P_DATA;

   modport master (
      output oP2S_DATA,
      output oSPI_GO,
      input  iSPI_END,
      input  iS2P_DATA
   );

   modport slave (
      input  oP2S_DATA,
      input  oSPI_GO,
      output iSPI_END,
      output iS2P_DATA
   );
endinterface

// File: rtl/adxl_spi_sequencer.sv
// ADXL345 command sequencer: writes the init table after reset, then periodically
// reads DATAX0..DATAZ1 and presents assembled signed X/Y/Z samples.
module adxl_spi_sequencer #(
   parameter int GAP_CYCLES     = 4,
   parameter int POLL_CYCLES    = 1000,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   input  logic                 iEN,
   adxl_spi_sequencer_if.master spi,
   output logic signed [15:0]   oX,
   output logic signed [15:0]   oY,
   output logic signed [15:0]   oZ,
   output logic                 oDATA_VALID,
   output logic                 oINIT_DONE,
   output logic                 oERR
);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP, S_POLL} state_t;

   localparam int CNT_MAX = (POLL_CYCLES > TIMEOUT_CYCLES) ?
                            ((POLL_CYCLES > GAP_CYCLES) ? POLL_CYCLES : GAP_CYCLES) :
                            ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES);
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic             init_ph_q, init_ph_d;   // 1: walking the init table, 0: read burst
   logic             fault_q, fault_d;       // current transfer timed out
   logic [15:0]      cmd_q, cmd_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [7:0]         stage_q [0:5];
   logic signed [15:0] x_q, y_q, z_q;
   logic               valid_q;
   logic               capture;

   // Command word for an init-table entry or a single-byte register read.
   function automatic logic [15:0] cmd_word(input logic init, input logic [2:0] idx);
      logic [5:0] addr;
      if (init) begin
         case (idx)
            3'd0:    return 16'h3140;
            3'd1:    return 16'h2C09;
            default: return 16'h2D08;
         endcase
      end
      addr = 6'h32 + {3'b000, idx};
      return {2'b10, addr, 8'h00};
   endfunction

   // Control state register.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         init_ph_q <= 1'b1;
         fault_q   <= 1'b0;
         cmd_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         init_ph_q <= init_ph_d;
         fault_q   <= fault_d;
         cmd_q     <= cmd_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic: transfer, inter-transfer gap, and poll interval sequencing.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      init_ph_d = init_ph_q;
      fault_d   = fault_q;
      cmd_d     = cmd_q;
      done_d    = done_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            state_d   = S_XFER;
            init_ph_d = 1'b1;
            idx_d     = '0;
            cnt_d     = '0;
         end
         S_XFER: begin
            // END takes priority over a timeout landing in the same cycle.
            if (spi.iSPI_END) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               state_d = S_GAP;
               cnt_d   = '0;
               err_d   = 1'b1;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_XFER;
               if (fault_q) begin
                  fault_d   = 1'b0;
                  init_ph_d = 1'b1;
                  idx_d     = '0;
                  done_d    = 1'b0;
               end else if (init_ph_q) begin
                  if (idx_q == 3'd2) begin
                     done_d    = 1'b1;
                     init_ph_d = 1'b0;
                     idx_d     = '0;
                     state_d   = S_POLL;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else if (idx_q == 3'd5) begin
                  idx_d   = '0;
                  state_d = S_POLL;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_POLL: begin
            if (!iEN) begin
               cnt_d = '0;
            end else if (cnt_q == POLL_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_XFER;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // The command word is only reloaded as a new transfer starts, so it is stable under GO.
      if (state_d == S_XFER && state_q != S_XFER) begin
         cmd_d = cmd_word(init_ph_d, idx_d);
      end
   end

   // The controller's last shift lands on the END cycle, so the byte is valid in the first gap cycle.
   assign capture = (state_q == S_GAP) && (cnt_q == '0) && !init_ph_q && !fault_q;

   // Read-byte staging and sample assembly; outputs update only on a complete burst.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         for (int i = 0; i < 6; i++) begin
            stage_q[i] <= '0;
         end
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (capture) begin
            stage_q[idx_q] <= spi.iS2P_DATA;
            if (idx_q == 3'd5) begin
               x_q     <= {stage_q[1], stage_q[0]};
               y_q     <= {stage_q[3], stage_q[2]};
               z_q     <= {spi.iS2P_DATA, stage_q[4]};
               valid_q <= 1'b1;
            end
         end
      end
   end

   assign spi.oSPI_GO   = (state_q == S_XFER);
   assign spi.oP2S_DATA = cmd_q;
   assign oX            = x_q;
   assign oY            = y_q;
   assign oZ            = z_q;
   assign oDATA_VALID   = valid_q;
   assign oINIT_DONE    = done_q;
   assign oERR          = err_q;

endmodule

// File: tb/tb_adxl_spi_sequencer.sv
// Bench for adxl_spi_sequencer: 3-wire SPI controller/sensor model plus a
// scoreboard of expected commands and samples checked by an output monitor.
module tb_adxl_spi_sequencer;

   localparam int GAP  = 4;
   localparam int POLL = 1000;
   localparam int TMO  = 64;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
   } smp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic signed [15:0] ox, oy, oz;
   logic               valid, done, err;

   adxl_spi_sequencer_if bus();

   adxl_spi_sequencer #(
      .GAP_CYCLES    (GAP),
      .POLL_CYCLES   (POLL),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .iCLK       (clk),
      .iRST       (rst),
      .iEN        (en),
      .spi        (bus),
      .oX         (ox),
      .oY         (oy),
      .oZ         (oz),
      .oDATA_VALID(valid),
      .oINIT_DONE (done),
      .oERR       (err)
   );

   always #5 clk = ~clk;

   int          n_chk;
   int          n_fail;
   logic [15:0] exp_cmd[$];
   smp_t        exp_smp[$];
   logic [7:0]  sens[6];
   logic        hang_en, late_en;
   logic [5:0]  hang_addr, late_addr;
   int          go_rises;
   int          valid_cnt;
   int          hi_len_by_addr[64];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_reads(input int count);
      for (int i = 0; i < count; i++) begin
         exp_cmd.push_back({8'hB2 + 8'(i), 8'h00});
      end
   endtask

   task automatic push_init();
      exp_cmd.push_back(16'h3140);
      exp_cmd.push_back(16'h2C09);
      exp_cmd.push_back(16'h2D08);
   endtask

   // Controller + sensor model: END in the 18th GO cycle, read byte held until next transfer.
   initial begin : ctrl_model
      int         gocnt;
      int         target;
      int         bi;
      logic [5:0] a;
      gocnt         = 0;
      bus.iSPI_END  = 1'b0;
      bus.iS2P_DATA = 8'h00;
      forever begin
         @(negedge clk);
         if (rst || !bus.oSPI_GO) begin
            gocnt        = 0;
            bus.iSPI_END = 1'b0;
         end else begin
            gocnt++;
            a      = bus.oP2S_DATA[13:8];
            target = 18;
            if (bus.oP2S_DATA[15] && hang_en && a == hang_addr) target = 0;
            else if (bus.oP2S_DATA[15] && late_en && a == late_addr) target = TMO;
            if (gocnt == target) begin
               bus.iSPI_END  = 1'b1;
               bi            = int'(a) - 'h32;
               bus.iS2P_DATA = (bi >= 0 && bi < 6) ? sens[bi] : 8'hEE;
            end else begin
               bus.iSPI_END = 1'b0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every GO rise and every valid strobe.
   initial begin : monitor
      logic        go_prev;
      int          low_cnt;
      int          hi_len;
      logic [15:0] held;
      logic        unstable;
      smp_t        e;
      go_prev   = 1'b0;
      low_cnt   = 1000;
      hi_len    = 0;
      held      = '0;
      unstable  = 1'b0;
      go_rises  = 0;
      valid_cnt = 0;
      for (int i = 0; i < 64; i++) hi_len_by_addr[i] = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            go_prev = 1'b0;
            low_cnt = 1000;
         end else begin
            if (bus.oSPI_GO && !go_prev) begin
               go_rises++;
               chk("gap_len_ge_min", {31'h0, low_cnt >= GAP}, 32'h1);
               if (exp_cmd.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_go: cmd %h, no command expected", bus.oP2S_DATA);
               end else begin
                  chk("go_cmd", {16'h0, bus.oP2S_DATA}, {16'h0, exp_cmd.pop_front()});
               end
               hi_len   = 1;
               held     = bus.oP2S_DATA;
               unstable = 1'b0;
            end else if (bus.oSPI_GO) begin
               hi_len++;
               if (bus.oP2S_DATA != held) unstable = 1'b1;
            end else if (go_prev) begin
               hi_len_by_addr[held[13:8]] = hi_len;
               chk("cmd_stable_under_go", {31'h0, unstable}, 32'h0);
               low_cnt = 1;
            end else begin
               low_cnt++;
            end
            if (valid) begin
               valid_cnt++;
               if (exp_smp.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_valid: x=%h y=%h z=%h, no sample expected", ox, oy, oz);
               end else begin
                  e = exp_smp.pop_front();
                  chk("sample_x", {16'h0, ox}, {16'h0, e.x});
                  chk("sample_y", {16'h0, oy}, {16'h0, e.y});
                  chk("sample_z", {16'h0, oz}, {16'h0, e.z});
               end
            end
            go_prev = bus.oSPI_GO;
         end
      end
   end

   // Directed stimulus.
   initial begin : stim
      int n;
      int r0;
      int v0;
      n_chk     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      en        = 1'b0;
      hang_en   = 1'b0;
      late_en   = 1'b0;
      hang_addr = 6'h33;
      late_addr = 6'h34;
      sens      = '{8'h34, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h01};

      repeat (3) @(negedge clk);
      chk("rst_p2s",   {16'h0, bus.oP2S_DATA}, 32'h0);
      chk("rst_go",    {31'h0, bus.oSPI_GO}, 32'h0);
      chk("rst_x",     {16'h0, ox}, 32'h0);
      chk("rst_y",     {16'h0, oy}, 32'h0);
      chk("rst_z",     {16'h0, oz}, 32'h0);
      chk("rst_valid", {31'h0, valid}, 32'h0);
      chk("rst_done",  {31'h0, done}, 32'h0);
      chk("rst_err",   {31'h0, err}, 32'h0);

      // Init table after reset release.
      push_init();
      rst = 1'b0;
      @(negedge clk);
      chk("first_go_latency", {31'h0, bus.oSPI_GO}, 32'h1);
      chk("first_cmd", {16'h0, bus.oP2S_DATA}, 32'h3140);
      n = 1;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("init_done_cycles", n, 67);
      chk("init_queue_empty", exp_cmd.size(), 0);

      // Polling disabled: no transfers at all.
      r0 = go_rises;
      repeat (5000) @(negedge clk);
      chk("en_low_no_go", go_rises - r0, 0);
      chk("en_low_go_level", {31'h0, bus.oSPI_GO}, 32'h0);

      // Enable: first read after POLL cycles; burst A.
      push_reads(6);
      exp_smp.push_back('{x: 16'h1234, y: 16'hFFFE, z: 16'h0100});
      v0 = valid_cnt;
      en = 1'b1;
      n  = 0;
      while (!bus.oSPI_GO && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("poll_latency", n, POLL);
      chk("first_read_cmd", {16'h0, bus.oP2S_DATA}, 32'hB200);
      n = 0;
      while (valid_cnt == v0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      chk("burstA_one_valid", valid_cnt - v0, 1);
      chk("burstA_read_len", hi_len_by_addr[6'h32], 18);

      // Burst B: END coincides with the timeout on the 0x34 read.
      sens    = '{8'h00, 8'h80, 8'h01, 8'h00, 8'hFF, 8'h7F};
      late_en = 1'b1;
      push_reads(6);
      exp_smp.push_back('{x: 16'h8000, y: 16'h0001, z: 16'h7FFF});
      v0 = valid_cnt;
      n  = 0;
      while (valid_cnt == v0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("burstB_valid_seen", valid_cnt - v0, 1);
      chk("coincide_len", hi_len_by_addr[6'h34], TMO);
      chk("coincide_no_err", {31'h0, err}, 32'h0);
      chk("coincide_done", {31'h0, done}, 32'h1);

      // Burst C: 0x33 read never ends -> timeout, restart from init.
      late_en = 1'b0;
      hang_en = 1'b1;
      sens    = '{8'h34, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h01};
      v0      = valid_cnt;
      exp_cmd.push_back(16'hB200);
      exp_cmd.push_back(16'hB300);
      push_init();
      push_reads(4);
      n = 0;
      while (!err && n < 2000) begin
         @(negedge clk);
         n++;
      end
      hang_en = 1'b0;
      chk("timeout_err", {31'h0, err}, 32'h1);
      chk("timeout_go_dropped", {31'h0, bus.oSPI_GO}, 32'h0);
      chk("timeout_go_len", hi_len_by_addr[6'h33], TMO);
      n = 0;
      while (!bus.oSPI_GO && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_gap", n, GAP);
      chk("restart_cmd", {16'h0, bus.oP2S_DATA}, 32'h3140);
      chk("restart_done_clr", {31'h0, done}, 32'h0);
      chk("timeout_x_kept", {16'h0, ox}, 32'h8000);
      chk("timeout_y_kept", {16'h0, oy}, 32'h0001);
      chk("timeout_z_kept", {16'h0, oz}, 32'h7FFF);
      chk("timeout_no_valid", valid_cnt - v0, 0);
      n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("reinit_done", {31'h0, done}, 32'h1);
      chk("err_sticky", {31'h0, err}, 32'h1);

      // Burst D: reset pulse during the 4th read.
      n = 0;
      while (!(bus.oSPI_GO && bus.oP2S_DATA == 16'hB500) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("reached_4th_read", {16'h0, bus.oP2S_DATA}, 32'hB500);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_go",    {31'h0, bus.oSPI_GO}, 32'h0);
      chk("midrst_p2s",   {16'h0, bus.oP2S_DATA}, 32'h0);
      chk("midrst_x",     {16'h0, ox}, 32'h0);
      chk("midrst_y",     {16'h0, oy}, 32'h0);
      chk("midrst_z",     {16'h0, oz}, 32'h0);
      chk("midrst_valid", {31'h0, valid}, 32'h0);
      chk("midrst_done",  {31'h0, done}, 32'h0);
      chk("midrst_err",   {31'h0, err}, 32'h0);
      exp_cmd.delete();
      push_init();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_go", {31'h0, bus.oSPI_GO}, 32'h1);
      chk("post_rst_cmd", {16'h0, bus.oP2S_DATA}, 32'h3140);
      n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("post_rst_done", {31'h0, done}, 32'h1);
      chk("cmd_queue_drained", exp_cmd.size(), 0);
      chk("smp_queue_drained", exp_smp.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
